wbdownsz: RTL

Bridges a wide Wishbone bus master onto a narrower Wishbone slave bus. This is the complement of the small-to-wide upsizer. Each accepted wide request is split into up to WIDE_DW/SMALL_DW pipelined narrow beats, and only beats whose select slice is non-zero are issued. Narrow read data is reassembled into one wide acknowledgement. It sits between wide-bus masters (DMA, SATA data path) and legacy narrow peripherals.

---
 rtl/wbdownsz.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wbdownsz.sv
// wbdownsz: wide-to-narrow Wishbone bridge. Each wide request becomes
// up to R pipelined narrow beats; narrow read data returns as one ack.
module wbdownsz #(
  parameter int   ADDRESS_WIDTH     = 28,
  parameter int   WIDE_DW           = 512,
  parameter int   SMALL_DW          = 32,
  parameter logic OPT_LITTLE_ENDIAN = 1'b0,
  parameter logic OPT_LOWPOWER      = 1'b0
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic                                        i_wcyc,
  input  logic                                        i_wstb,
  input  logic                                        i_wwe,
  input  logic [ADDRESS_WIDTH-$clog2(WIDE_DW/8)-1:0]  i_waddr,
  input  logic [WIDE_DW-1:0]                          i_wdata,
  input  logic [WIDE_DW/8-1:0]                        i_wsel,
  output logic                                        o_wstall,
  output logic                                        o_wack,
  output logic [WIDE_DW-1:0]                          o_wdata,
  output logic                                        o_werr,
  output logic                                        o_scyc,
  output logic                                        o_sstb,
  output logic                                        o_swe,
  output logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0] o_saddr,
  output logic [SMALL_DW-1:0]                         o_sdata,
  output logic [SMALL_DW/8-1:0]                       o_ssel,
  input  logic                                        i_sstall,
  input  logic                                        i_sack,
  input  logic                                        i_serr,
  input  logic [SMALL_DW-1:0]                         i_sdata
);
  localparam int R   = WIDE_DW / SMALL_DW;
  localparam int LGR = $clog2(R);
  localparam int WAW = ADDRESS_WIDTH - $clog2(WIDE_DW/8);
  localparam int SB  = SMALL_DW / 8;
  localparam int WB  = WIDE_DW / 8;

  // bit / byte offset of beat k within the wide word
  function automatic int doff(input int k);
    return OPT_LITTLE_ENDIAN ? k*SMALL_DW : WIDE_DW - (k+1)*SMALL_DW;
  endfunction

  function automatic int soff(input int k);
    return OPT_LITTLE_ENDIAN ? k*SB : WB - (k+1)*SB;
  endfunction

  logic               busy_q, busy_d;
  logic               we_q, we_d;
  logic [WAW-1:0]     addr_q, addr_d;
  logic [WIDE_DW-1:0] data_q, data_d;
  logic [WB-1:0]      sel_q, sel_d;
  logic [R-1:0]       imask_q, imask_d;
  logic [R-1:0]       amask_q, amask_d;
  logic [WIDE_DW-1:0] rdata_q, rdata_d;
  logic               wack_q, wack_d;
  logic               werr_q, werr_d;
  logic [R-1:0]       nmask;
  logic [LGR-1:0]     iidx, aidx;

  always_comb begin
    iidx = '0;
    aidx = '0;
    for (int k = R-1; k >= 0; k--) begin
      if (imask_q[k]) iidx = LGR'(k);
      if (amask_q[k]) aidx = LGR'(k);
    end
  end

  always_comb begin
    nmask = '0;
    for (int k = 0; k < R; k++)
      nmask[k] = |i_wsel[soff(k) +: SB];
  end

  always_comb begin
    busy_d  = busy_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    imask_d = imask_q;
    amask_d = amask_q;
    rdata_d = rdata_q;
    wack_d  = 1'b0;
    werr_d  = 1'b0;
    if (busy_q) begin
      if (!i_wcyc) begin
        busy_d  = 1'b0;
        imask_d = '0;
        amask_d = '0;
      end else if (i_serr && |amask_q) begin
        werr_d  = 1'b1;
        busy_d  = 1'b0;
        imask_d = '0;
        amask_d = '0;
      end else begin
        if (o_sstb && !i_sstall)
          imask_d[iidx] = 1'b0;
        if (i_sack && |amask_q) begin
          rdata_d[doff(int'(aidx)) +: SMALL_DW] = i_sdata;
          amask_d[aidx] = 1'b0;
          if (amask_d == '0) begin
            busy_d  = 1'b0;
            wack_d  = 1'b1;
            imask_d = '0;
          end
        end
      end
    end else if (i_wcyc && i_wstb) begin
      we_d    = i_wwe;
      addr_d  = i_waddr;
      data_d  = i_wdata;
      sel_d   = i_wsel;
      imask_d = nmask;
      amask_d = nmask;
      rdata_d = '0;
      // an all-zero select is answered without touching the narrow bus
      busy_d  = |nmask;
      wack_d  = ~|nmask;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      imask_q <= '0;
      amask_q <= '0;
      rdata_q <= '0;
      wack_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      imask_q <= imask_d;
      amask_q <= amask_d;
      rdata_q <= rdata_d;
      wack_q  <= wack_d;
      werr_q  <= werr_d;
    end
  end

  assign o_wstall = busy_q;
  assign o_scyc   = busy_q;
  assign o_sstb   = busy_q && |imask_q;
  assign o_swe    = busy_q && we_q;
  assign o_wack   = wack_q;
  assign o_werr   = werr_q;

  always_comb begin
    o_saddr = {addr_q, iidx};
    o_sdata = data_q[doff(int'(iidx)) +: SMALL_DW];
    o_ssel  = sel_q[soff(int'(iidx)) +: SB];
    o_wdata = rdata_q;
    if (OPT_LOWPOWER && !o_sstb) begin
      o_saddr = '0;
      o_sdata = '0;
      o_ssel  = '0;
    end
    if (OPT_LOWPOWER && !wack_q)
      o_wdata = '0;
  end
endmodule
